cdemux3_credit_5b: RTL

- Synchronous 1-to-3 split for the drive/free pulse handshake used by the control fabric; the dispatch-side counterpart of the 3-way mutex merge.
- Accepts one token (data plus route select) from a single upstream channel and forwards it to exactly one of three downstream channels.
- Each output is gated by a per-port credit counter fed by that port's free pulses.
- Sits between a merged request FIFO and three per-bank consumers.

---
 rtl/cdemux3_credit_5b.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cdemux3_credit_5b.sv
// 1-to-3 credit-gated token demux on the drive/free pulse handshake.
// Tokens with credit on their port are forwarded the cycle after capture; others wait in S_HOLD.
module cdemux3_credit_5b #(
  parameter int DW          = 5,
  parameter int CW          = 2,
  parameter int CREDIT_MAX  = 3,
  parameter int INIT_CREDIT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_drive,
  input  logic [DW-1:0] i_data,
  input  logic [1:0]    i_sel,
  output logic          o_free,
  output logic          o_drive0,
  output logic          o_drive1,
  output logic          o_drive2,
  output logic [DW-1:0] o_data0,
  output logic [DW-1:0] o_data1,
  output logic [DW-1:0] o_data2,
  input  logic          i_free0,
  input  logic          i_free1,
  input  logic          i_free2,
  output logic          o_busy,
  output logic          o_err
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [DW-1:0]   data_r;
  logic [1:0]      sel_r;
  logic [CW-1:0]   credit_r [3];
  logic [CW-1:0]   credit_next_s [3];
  logic [2:0]      free_in_s;
  logic            dispatch_s;
  logic [1:0]      disp_sel_s;
  logic [DW-1:0]   disp_data_s;
  logic [2:0]      disp_vec_s;
  logic            capture_s;
  logic            illegal_s;
  logic            proto_err_s;
  logic            sat_err_s;
  logic            free_pulse_s;

  logic            free_r;
  logic [2:0]      drive_r;
  logic [DW-1:0]   data0_r;
  logic [DW-1:0]   data1_r;
  logic [DW-1:0]   data2_r;
  logic            busy_r;
  logic            err_r;

  function automatic logic has_credit(input logic [1:0] sel, input logic [CW-1:0] c0,
                                      input logic [CW-1:0] c1, input logic [CW-1:0] c2);
    case (sel)
      2'd0:    has_credit = (c0 != {CW{1'b0}});
      2'd1:    has_credit = (c1 != {CW{1'b0}});
      2'd2:    has_credit = (c2 != {CW{1'b0}});
      default: has_credit = 1'b0;
    endcase
  endfunction

  assign free_in_s = {i_free2, i_free1, i_free0};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_INIT: next_state_s = S_IDLE;
      S_IDLE: begin
        if (i_drive && (i_sel != 2'd3) &&
            !has_credit(i_sel, credit_r[0], credit_r[1], credit_r[2])) begin
          next_state_s = S_HOLD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_HOLD: begin
        if (has_credit(sel_r, credit_r[0], credit_r[1], credit_r[2])) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_HOLD;
        end
      end
      default: next_state_s = S_INIT;
    endcase
  end

  // Output decode: dispatch, capture, upstream credit and protocol errors
  always_comb begin
    dispatch_s   = 1'b0;
    disp_sel_s   = sel_r;
    disp_data_s  = data_r;
    capture_s    = 1'b0;
    illegal_s    = 1'b0;
    proto_err_s  = 1'b0;
    free_pulse_s = 1'b0;
    case (state_r)
      S_INIT: begin
        free_pulse_s = 1'b1;
        proto_err_s  = i_drive;
      end
      S_IDLE: begin
        if (i_drive) begin
          capture_s = 1'b1;
          if (i_sel == 2'd3) begin
            illegal_s    = 1'b1;
            free_pulse_s = 1'b1;
          end else if (has_credit(i_sel, credit_r[0], credit_r[1], credit_r[2])) begin
            dispatch_s   = 1'b1;
            disp_sel_s   = i_sel;
            disp_data_s  = i_data;
            free_pulse_s = 1'b1;
          end else begin
            dispatch_s = 1'b0;
          end
        end else begin
          capture_s = 1'b0;
        end
      end
      S_HOLD: begin
        proto_err_s = i_drive;
        if (has_credit(sel_r, credit_r[0], credit_r[1], credit_r[2])) begin
          dispatch_s   = 1'b1;
          free_pulse_s = 1'b1;
        end else begin
          dispatch_s = 1'b0;
        end
      end
      default: begin
        dispatch_s = 1'b0;
      end
    endcase
  end

  // One-hot port strobe for the dispatch decision
  always_comb begin
    disp_vec_s = 3'b000;
    if (dispatch_s) begin
      case (disp_sel_s)
        2'd0:    disp_vec_s = 3'b001;
        2'd1:    disp_vec_s = 3'b010;
        2'd2:    disp_vec_s = 3'b100;
        default: disp_vec_s = 3'b000;
      endcase
    end else begin
      disp_vec_s = 3'b000;
    end
  end

  // Credit arithmetic: a free and a dispatch on the same port cancel; frees saturate at CREDIT_MAX
  always_comb begin
    sat_err_s = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (free_in_s[n] && !disp_vec_s[n]) begin
        if (credit_r[n] == CW'(CREDIT_MAX)) begin
          credit_next_s[n] = credit_r[n];
          sat_err_s        = 1'b1;
        end else begin
          credit_next_s[n] = credit_r[n] + CW'(1);
        end
      end else if (!free_in_s[n] && disp_vec_s[n]) begin
        credit_next_s[n] = credit_r[n] - CW'(1);
      end else begin
        credit_next_s[n] = credit_r[n];
      end
    end
  end

  // Credit counters and held token
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < 3; n++) begin
        credit_r[n] <= CW'(INIT_CREDIT);
      end
      data_r <= {DW{1'b0}};
      sel_r  <= 2'd0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        credit_r[n] <= credit_next_s[n];
      end
      if (capture_s) begin
        data_r <= i_data;
        sel_r  <= i_sel;
      end
    end
  end

  // Registered outputs; port data registers only move on their own delivery
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_r  <= 1'b0;
      drive_r <= 3'b000;
      data0_r <= {DW{1'b0}};
      data1_r <= {DW{1'b0}};
      data2_r <= {DW{1'b0}};
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      free_r  <= free_pulse_s;
      drive_r <= disp_vec_s;
      if (disp_vec_s[0]) data0_r <= disp_data_s;
      if (disp_vec_s[1]) data1_r <= disp_data_s;
      if (disp_vec_s[2]) data2_r <= disp_data_s;
      busy_r  <= (next_state_s == S_HOLD);
      err_r   <= err_r | proto_err_s | illegal_s | sat_err_s;
    end
  end

  assign o_free   = free_r;
  assign o_drive0 = drive_r[0];
  assign o_drive1 = drive_r[1];
  assign o_drive2 = drive_r[2];
  assign o_data0  = data0_r;
  assign o_data1  = data1_r;
  assign o_data2  = data2_r;
  assign o_busy   = busy_r;
  assign o_err    = err_r;

endmodule
